conv3x3_stream: RTL and testbench

- Streaming 3x3 2-D convolution engine; parametrised successor to the fixed 10x10 row-PE array.
- Accepts one raster-order pixel per cycle over valid/ready and keeps two internal line buffers.
- Emits one "valid" (no-padding) convolution result per accepted window through a 2-stage multiply/adder-tree pipeline with backpressure.
- Sits between the pixel source and the feature-map writer in the VLSI datapath.

---
 rtl/conv_pkg.sv | 17 +
 rtl/conv3x3_stream_line_buffer.sv | 28 ++
 rtl/conv3x3_stream.sv | 154 +++++++++++++++
 tb/tb_conv3x3_stream.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and width helpers for the 3x3 convolution engine.
package conv_pkg;

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    localparam int TAPS = 9;

    function automatic int prod_w(input int data_w, input int coef_w);
        return data_w + coef_w;
    endfunction

    // Nine products need four extra bits to add without overflow.
    function automatic int sum_w(input int data_w, input int coef_w);
        return prod_w(data_w, coef_w) + 4;
    endfunction

endpackage

// File: rtl/conv3x3_stream_line_buffer.sv
// line_buffer: DEPTH-deep shift line, output is the sample shifted in DEPTH enables ago.
// Zero latency beyond DEPTH shifts; holds entirely while i_en is low.
module line_buffer
    import conv_pkg::*;
#(
    parameter int DEPTH = 10,
    parameter int W     = 2
) (
    input  logic         i_clk,
    input  logic         i_en,
    input  logic [W-1:0] i_dat,
    output logic [W-1:0] o_dat
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            r_mem[0] <= i_dat;
            for (int i = 1; i < DEPTH; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    assign o_dat = r_mem[DEPTH-1];

endmodule

// File: rtl/conv3x3_stream.sv
// conv3x3_stream: raster-streamed 3x3 valid-mode convolution; result 2 cycles after its last pixel, whole pipe freezes on out stall.
// Build option CONV3X3_SAT_EN: clamp the sum to 2^ACC_W-1 instead of wrapping.
module conv3x3_stream
    import conv_pkg::*;
#(
    parameter int IMG_W  = 10,
    parameter int IMG_H  = 10,
    parameter int DATA_W = 2,
    parameter int COEF_W = 2,
    parameter int ACC_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   coef_load,
    input  logic [9*COEF_W-1:0]    coef_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_pix,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_W-1:0]       out_pix,
    output logic                   frame_done
);

    localparam int PROD_W = prod_w(DATA_W, COEF_W);
    localparam int SUM_W  = sum_w(DATA_W, COEF_W);
    localparam int ROW_W  = $clog2(IMG_H);
    localparam int COL_W  = $clog2(IMG_W);

    state_t                  r_state, w_state_nxt;
    logic [ROW_W-1:0]        r_row;
    logic [COL_W-1:0]        r_col;
    logic [TAPS*COEF_W-1:0]  r_coef;
    logic [DATA_W-1:0]       r_win     [3][3];
    logic [DATA_W-1:0]       w_win_nxt [3][3];
    logic [DATA_W-1:0]       w_lb0, w_lb1;
    logic [PROD_W-1:0]       r_prod [TAPS];
    logic [PROD_W-1:0]       w_prod [TAPS];
    logic [SUM_W-1:0]        w_sum;
    logic [ACC_W-1:0]        w_red;
    logic [ACC_W-1:0]        r_out;
    logic                    r_v1, r_v2;
    logic                    w_stall, w_accept, w_issue, w_last_pix;
    logic                    w_in_ready, w_frame_done;

    assign w_stall    = r_v2 & ~out_ready;
    assign w_accept   = in_valid & in_ready;
    assign w_last_pix = (r_row == ROW_W'(IMG_H-1)) && (r_col == COL_W'(IMG_W-1));
    assign w_issue    = w_accept && (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));

    always_comb begin
        w_state_nxt  = r_state;
        w_in_ready   = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = ~coef_load;
                if (in_valid && !coef_load) w_state_nxt = STREAM;
            end
            STREAM: begin
                w_in_ready = ~w_stall;
                if (in_valid && !w_stall && w_last_pix) w_state_nxt = FLUSH;
            end
            FLUSH: begin
                // The final result is the one leaving with stage 1 already empty.
                if (r_v2 && out_ready && !r_v1) begin
                    w_frame_done = 1'b1;
                    w_state_nxt  = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign in_ready   = w_in_ready & ~rst;
    assign frame_done = w_frame_done;
    assign out_valid  = r_v2;
    assign out_pix    = r_out;

    line_buffer #(.DEPTH(IMG_W), .W(DATA_W)) u_lb0 (
        .i_clk(clk), .i_en(w_accept), .i_dat(in_pix), .o_dat(w_lb0)
    );
    line_buffer #(.DEPTH(IMG_W), .W(DATA_W)) u_lb1 (
        .i_clk(clk), .i_en(w_accept), .i_dat(w_lb0), .o_dat(w_lb1)
    );

    // Products are taken from the post-shift window so stage 1 loads on the accept edge.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            w_win_nxt[r][0] = r_win[r][1];
            w_win_nxt[r][1] = r_win[r][2];
            w_win_nxt[r][2] = '0;
        end
        w_win_nxt[0][2] = w_lb1;
        w_win_nxt[1][2] = w_lb0;
        w_win_nxt[2][2] = in_pix;
        for (int k = 0; k < TAPS; k++) begin
            w_prod[k] = PROD_W'(w_win_nxt[k/3][k%3]) * PROD_W'(r_coef[k*COEF_W +: COEF_W]);
        end
    end

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < TAPS; k++) begin
            w_sum = w_sum + SUM_W'(r_prod[k]);
        end
    end

`ifdef CONV3X3_SAT_EN
    logic w_ovf;
    if (SUM_W > ACC_W) begin : g_ovf
        assign w_ovf = |w_sum[SUM_W-1:ACC_W];
    end else begin : g_no_ovf
        assign w_ovf = 1'b0;
    end
    assign w_red = w_ovf ? {ACC_W{1'b1}} : ACC_W'(w_sum);
`else
    assign w_red = ACC_W'(w_sum);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_row   <= '0;
            r_col   <= '0;
            r_coef  <= '0;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_out   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && coef_load) r_coef <= coef_in;
            if (w_accept) begin
                if (r_col == COL_W'(IMG_W-1)) begin
                    r_col <= '0;
                    r_row <= (r_row == ROW_W'(IMG_H-1)) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            if (!w_stall) begin
                r_v1 <= w_issue;
                r_v2 <= r_v1;
                if (r_v1) r_out <= w_red;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) r_win  <= w_win_nxt;
        if (w_issue)  r_prod <= w_prod;
    end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Randomised self-checking bench: a 16-bit and a 6-bit result instance share stimulus against a window-sum model.
module tb_conv3x3_stream;

    localparam int W  = 10;
    localparam int H  = 10;
    localparam int CW = 2;

    logic        clk = 1'b0;
    logic        rst, coef_load, in_valid, out_ready;
    logic [17:0] coef_in;
    logic [1:0]  in_pix;
    logic        in_ready, out_valid, frame_done;
    logic [15:0] out_pix;
    logic        in_ready6, out_valid6, frame_done6;
    logic [5:0]  out_pix6;

    conv3x3_stream #(.IMG_W(W), .IMG_H(H), .DATA_W(2), .COEF_W(CW), .ACC_W(16)) u_dut (
        .clk(clk), .rst(rst), .coef_load(coef_load), .coef_in(coef_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
        .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix),
        .frame_done(frame_done)
    );

    conv3x3_stream #(.IMG_W(W), .IMG_H(H), .DATA_W(2), .COEF_W(CW), .ACC_W(6)) u_dut6 (
        .clk(clk), .rst(rst), .coef_load(coef_load), .coef_in(coef_in),
        .in_valid(in_valid), .in_ready(in_ready6), .in_pix(in_pix),
        .out_valid(out_valid6), .out_ready(out_ready), .out_pix(out_pix6),
        .frame_done(frame_done6)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int img [H][W];
    int cf [9];
    int exp_q [$];
    int fd_cnt = 0;
    int res_cnt = 0;
    int rdy_mode = 0;
    bit first_seen;
    int first_cyc, acc22_cyc;
    bit prev_stall = 0;
    int prev_pix = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int red6(input int s);
`ifdef CONV3X3_SAT_EN
        return (s > 63) ? 63 : s;
`else
        return s % 64;
`endif
    endfunction

    function automatic logic [17:0] pack_coef();
        logic [17:0] v;
        v = '0;
        for (int k = 0; k < 9; k++) v[k*CW +: CW] = CW'(cf[k]);
        return v;
    endfunction

    // Model: every full 3x3 window whose bottom-right corner is at row>=2, col>=2, raster order.
    task automatic push_expect();
        for (int r = 2; r < H; r++) begin
            for (int c = 2; c < W; c++) begin
                int s;
                s = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        s += img[r-2+i][c-2+j] * cf[i*3+j];
                exp_q.push_back(s);
            end
        end
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                1:       out_ready = ~out_ready;
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            chk("ctl6", int'({in_ready6, out_valid6, frame_done6}), int'({in_ready, out_valid, frame_done}));
            if (prev_stall) begin
                chk("hold_vld", int'(out_valid), 1);
                chk("hold_pix", int'(out_pix), prev_pix);
            end
            if (frame_done) begin
                fd_cnt++;
                chk("fd_last", int'(out_valid && out_ready && exp_q.size() == 1), 1);
            end
            if (out_valid) begin
                if (!first_seen) begin
                    first_seen = 1;
                    first_cyc  = cyc;
                end
                if (exp_q.size() == 0) begin
                    chk("extra_result", 1, 0);
                end else begin
                    chk("pix", int'(out_pix), exp_q[0]);
                    chk("pix6", int'(out_pix6), red6(exp_q[0]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        res_cnt++;
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_pix   = int'(out_pix);
        end
    end

    task automatic load_coef();
        @(posedge clk); #1;
        coef_load = 1'b1;
        coef_in   = pack_coef();
        @(negedge clk);
        chk("load_rdy", int'(in_ready), 0);
        @(posedge clk); #1;
        coef_load = 1'b0;
    endtask

    task automatic send_frame(input int npix, input bit idle_load, input bit stream_load);
        bit ok;
        first_seen = 0;
        acc22_cyc  = -1;
        @(posedge clk); #1;
        if (idle_load) begin
            coef_load = 1'b1;
            coef_in   = pack_coef();
            in_valid  = 1'b1;
            in_pix    = 2'(img[0][0]);
            @(negedge clk);
            chk("idle_load_rdy", int'(in_ready), 0);
            @(posedge clk); #1;
            coef_load = 1'b0;
        end
        for (int n = 0; n < npix; n++) begin
            in_valid = 1'b1;
            in_pix   = 2'(img[n/W][n%W]);
            if (stream_load && n == 30) begin
                coef_load = 1'b1;
                coef_in   = ~pack_coef();
            end
            ok = 0;
            for (int t = 0; t < 100; t++) begin
                @(negedge clk);
                if (idle_load && n == 0 && t == 0) chk("idle_take", int'(in_ready), 1);
                if (in_ready) begin
                    ok = 1;
                    if (n == 2*W+2) acc22_cyc = cyc;
                end
                @(posedge clk); #1;
                if (ok) break;
            end
            coef_load = 1'b0;
            if (!ok) begin
                chk("in_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input int mode, input bit idle_load, input bit stream_load);
        int fd0, r0;
        fd0 = fd_cnt;
        r0  = res_cnt;
        rdy_mode = mode;
        push_expect();
        send_frame(W*H, idle_load, stream_load);
        for (int t = 0; t < 400; t++) begin
            if (exp_q.size() == 0 && fd_cnt > fd0) break;
            @(posedge clk);
        end
        chk("drain", exp_q.size(), 0);
        chk("fd_count", fd_cnt - fd0, 1);
        chk("n_results", res_cnt - r0, (W-2)*(H-2));
        rdy_mode = 0;
        exp_q.delete();
    endtask

    task automatic set_all(input int cval, input int pval);
        for (int k = 0; k < 9; k++) cf[k] = cval;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = pval;
    endtask

    initial begin
        int fd0;
        rst = 1'b1; coef_load = 1'b0; coef_in = '0; in_valid = 1'b0; in_pix = '0;
        #2;
        chk("rst_vld", int'(out_valid), 0);
        chk("rst_pix", int'(out_pix), 0);
        chk("rst_fd", int'(frame_done), 0);
        chk("rst_rdy", int'(in_ready), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        set_all(1, 1);
        load_coef();
        run_frame(0, 0, 0);
        chk("latency", first_cyc - acc22_cyc, 2);

        set_all(0, 0);
        cf[4] = 1;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = (r + c) % 4;
        load_coef();
        run_frame(0, 0, 0);

        set_all(1, 1);
        load_coef();
        run_frame(1, 0, 0);

        set_all(3, 3);
        load_coef();
        run_frame(2, 0, 0);

        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 9; k++) cf[k] = $urandom_range(0, 3);
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++) img[r][c] = $urandom_range(0, 3);
            load_coef();
            run_frame(2, 0, f == 1);
        end

        // Abort a frame after 37 pixels with reset.
        set_all(1, 1);
        load_coef();
        push_expect();
        send_frame(37, 0, 0);
        rst = 1'b1;
        #1;
        chk("abort_vld", int'(out_valid), 0);
        chk("abort_rdy", int'(in_ready), 0);
        chk("abort_fd", int'(frame_done), 0);
        exp_q.delete();
        fd0 = fd_cnt;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("abort_no_fd", fd_cnt - fd0, 0);
        chk("abort_idle_rdy", int'(in_ready), 1);

        // Coefficients were cleared by reset.
        set_all(0, 1);
        run_frame(0, 0, 0);

        set_all(1, 1);
        load_coef();
        run_frame(0, 0, 0);

        for (int k = 0; k < 9; k++) cf[k] = $urandom_range(0, 3);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = $urandom_range(0, 3);
        run_frame(1, 1, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
